ssd_scan_sequencer: RTL and testbench

Time-multiplexed scan controller for the 4-digit seven-segment display. It owns the refresh divider and digit counter, and double-buffers four BCD digits so a frame is never torn mid-scan. It applies an inter-digit blanking interval (anti-ghosting), a per-digit enable mask and leading-zero suppression. It drives the active-low digit-select and the BCD nibble into the existing BCD-to-segment decoder.

---
 rtl/ssd_scan_sequencer_if.sv | 24 ++
 rtl/ssd_scan_sequencer.sv | 80 ++++++++
 tb/tb_ssd_scan_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ssd_scan_sequencer_if.sv
// Display-scan bundle: staged BCD digits and controls in, digit select and nibble out.
interface ssd_scan_sequencer_if;
  logic [3:0] in3;
  logic [3:0] in2;
  logic [3:0] in1;
  logic [3:0] in0;
  logic       load;
  logic [3:0] digit_en;
  logic       lz_blank;
  logic [3:0] ssd_ctl;
  logic [3:0] ssd_in;
  logic       load_ack;
  logic       frame_done;

  modport master (
    output in3, in2, in1, in0, load, digit_en, lz_blank,
    input  ssd_ctl, ssd_in, load_ack, frame_done
  );

  modport slave (
    input  in3, in2, in1, in0, load, digit_en, lz_blank,
    output ssd_ctl, ssd_in, load_ack, frame_done
  );
endinterface

// File: rtl/ssd_scan_sequencer.sv
// 4-digit seven-segment scan controller: refresh divider, frame-synchronous double buffer,
// inter-digit blanking, digit mask and leading-zero suppression; all outputs 1-cycle registered.
module ssd_scan_sequencer #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 1000
) (
  input logic                 clk,
  input logic                 rst_n,
  ssd_scan_sequencer_if.slave bus
);
  localparam logic [15:0] CNT_LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0] BLANK    = 16'(BLANK_CYC);

  logic [15:0]      cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0][3:0]  stage_q, stage_d;
  logic [3:0][3:0]  disp_q, disp_d;
  logic             pending_q, pending_d;
  logic [3:0]       ssd_ctl_q, ssd_ctl_d;
  logic [3:0]       ssd_in_q, ssd_in_d;
  logic             load_ack_q, load_ack_d;
  logic             frame_done_q, frame_done_d;
  logic             wrap, boundary, suppressed, lit;

  always_comb begin
    wrap      = (cnt_q == CNT_LAST);
    boundary  = wrap && (idx_q == 2'd3);
    cnt_d     = wrap ? 16'd0 : cnt_q + 16'd1;
    idx_d     = wrap ? idx_q + 2'd1 : idx_q;
    stage_d   = bus.load ? {bus.in3, bus.in2, bus.in1, bus.in0} : stage_q;
    // A load on the boundary re-arms pending for the value it just wrote.
    pending_d = bus.load | (pending_q & ~boundary);
    disp_d    = (boundary && pending_q) ? stage_q : disp_q;

    suppressed = 1'b0;
    if (bus.lz_blank) begin
      case (idx_q)
        2'd1:    suppressed = (disp_q[3:1] == '0);
        2'd2:    suppressed = (disp_q[3:2] == '0);
        2'd3:    suppressed = (disp_q[3] == 4'h0);
        default: suppressed = 1'b0;
      endcase
    end
    lit = bus.digit_en[idx_q] && !suppressed;

    ssd_in_d     = lit ? disp_q[idx_q] : 4'h0;
    ssd_ctl_d    = (lit && cnt_q >= BLANK) ? ~(4'b0001 << idx_q) : 4'b1111;
    load_ack_d   = boundary && pending_q;
    frame_done_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      stage_q      <= '0;
      disp_q       <= '0;
      pending_q    <= 1'b0;
      ssd_ctl_q    <= 4'b1111;
      ssd_in_q     <= 4'h0;
      load_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      stage_q      <= stage_d;
      disp_q       <= disp_d;
      pending_q    <= pending_d;
      ssd_ctl_q    <= ssd_ctl_d;
      ssd_in_q     <= ssd_in_d;
      load_ack_q   <= load_ack_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.ssd_ctl    = ssd_ctl_q;
  assign bus.ssd_in     = ssd_in_q;
  assign bus.load_ack   = load_ack_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_ssd_scan_sequencer.sv
// Bench for ssd_scan_sequencer with SCAN_DIV=4, BLANK_CYC=1: per-cycle scoreboard plus table and corner sequences.
module tb_ssd_scan_sequencer;
  localparam int SD = 4;
  localparam int BC = 1;
  localparam int FR = 4 * SD;

  logic clk = 1'b0;
  logic rst_n;
  ssd_scan_sequencer_if bus();

  ssd_scan_sequencer #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] ctl;
    logic [3:0] din;
    logic       ack;
    logic       fd;
  } exp_t;

  typedef struct packed {
    logic [15:0] digs;     // in3..in0
    logic [3:0]  en;
    logic        lz;
    logic [15:0] exp_in;   // slot3..slot0
    logic [3:0]  exp_lit;  // bit k = slot k lit
  } vec_t;

  exp_t            sb_q[$];
  int              nvec = 0;
  int              nerr = 0;
  int              ack_cnt = 0;
  int              fd_cnt = 0;
  logic [3:0][3:0] m_disp, m_stage;
  logic            m_pend;
  int              m_t;

  // Expected outputs from absolute time since reset release, queued before the edge.
  task automatic step();
    exp_t e, g;
    int slot, pos;
    logic supp, lit;
    if (!rst_n) begin
      e = '{ctl: 4'hf, din: 4'h0, ack: 1'b0, fd: 1'b0};
      m_t = 0; m_disp = '0; m_stage = '0; m_pend = 1'b0;
    end else begin
      slot = (m_t / SD) % 4;
      pos  = m_t % SD;
      supp = 1'b0;
      if (bus.lz_blank && slot != 0) begin
        supp = 1'b1;
        for (int k = slot; k < 4; k++) if (m_disp[k] != 4'h0) supp = 1'b0;
      end
      lit   = bus.digit_en[slot] && !supp;
      e.din = lit ? m_disp[slot] : 4'h0;
      e.ctl = (lit && pos >= BC) ? ~(4'b0001 << slot) : 4'hf;
      e.fd  = (m_t % FR) == FR - 1;
      e.ack = e.fd && m_pend;
      if (e.ack) begin m_disp = m_stage; m_pend = 1'b0; end
      if (bus.load) begin m_stage = {bus.in3, bus.in2, bus.in1, bus.in0}; m_pend = 1'b1; end
      m_t++;
    end
    sb_q.push_back(e);
    @(posedge clk); #1;
    g = sb_q.pop_front();
    nvec++;
    if (bus.ssd_ctl !== g.ctl || bus.ssd_in !== g.din || bus.load_ack !== g.ack || bus.frame_done !== g.fd) begin
      nerr++;
      $display("FAIL scan t=%0d: got ctl=%b in=%h ack=%b fd=%b, want ctl=%b in=%h ack=%b fd=%b",
               m_t, bus.ssd_ctl, bus.ssd_in, bus.load_ack, bus.frame_done, g.ctl, g.din, g.ack, g.fd);
    end
    if (bus.load_ack === 1'b1) ack_cnt++;
    if (bus.frame_done === 1'b1) fd_cnt++;
  endtask

  task automatic chk(input string nm, input int got, input int want);
    nvec++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic step_load(input logic [15:0] d);
    {bus.in3, bus.in2, bus.in1, bus.in0} = d;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
  endtask

  task automatic run_to(input int ph);
    for (int i = 0; i < FR && (m_t % FR) != ph; i++) step();
  endtask

  task automatic wait_ack(input string nm);
    int a0;
    a0 = ack_cnt;
    for (int i = 0; i < 3 * FR && ack_cnt == a0; i++) step();
    chk({nm, "_ack_seen"}, ack_cnt - a0, 1);
  endtask

  vec_t tbl[7];
  logic [3:0] stream[16];

  initial begin
    int a0, f0, nz;
    tbl[0] = '{16'h1234, 4'b1111, 1'b0, 16'h1234, 4'b1111};
    tbl[1] = '{16'h0050, 4'b1111, 1'b1, 16'h0050, 4'b0011};
    tbl[2] = '{16'h0000, 4'b1111, 1'b1, 16'h0000, 4'b0001};
    tbl[3] = '{16'h6789, 4'b1010, 1'b0, 16'h6080, 4'b1010};
    tbl[4] = '{16'hF0A0, 4'b1111, 1'b1, 16'hF0A0, 4'b1111};
    tbl[5] = '{16'h0700, 4'b1111, 1'b1, 16'h0700, 4'b0111};
    tbl[6] = '{16'h0003, 4'b1111, 1'b1, 16'h0003, 4'b0001};
    for (int i = 0; i < 16; i++)
      stream[i] = (i % 4 == 0) ? 4'b1111 : ~(4'b0001 << (i / 4));

    rst_n = 1'b0;
    bus.load = 1'b0; bus.digit_en = 4'b1111; bus.lz_blank = 1'b0;
    {bus.in3, bus.in2, bus.in1, bus.in0} = 16'h0;
    repeat (3) step();
    chk("reset_ctl", bus.ssd_ctl, 4'b1111);
    chk("reset_in", bus.ssd_in, 0);

    rst_n = 1'b1;
    f0 = fd_cnt;
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("stream_%0d", i), bus.ssd_ctl, stream[i]);
    end
    repeat (16) step();
    chk("frame_done_per_2frames", fd_cnt - f0, 2);

    for (int v = 0; v < 7; v++) begin
      bus.digit_en = tbl[v].en;
      bus.lz_blank = tbl[v].lz;
      run_to(6);
      step_load(tbl[v].digs);
      wait_ack($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_ack_with_fd", v), bus.frame_done, 1);
      for (int i = 0; i < FR; i++) begin
        step();
        if (i % 4 == 2) begin
          chk($sformatf("vec%0d_slot%0d_in", v, i / 4), bus.ssd_in, tbl[v].exp_in[(i / 4) * 4 +: 4]);
          chk($sformatf("vec%0d_slot%0d_ctl", v, i / 4), bus.ssd_ctl,
              tbl[v].exp_lit[i / 4] ? ~(4'b0001 << (i / 4)) & 4'hf : 4'hf);
        end
      end
    end

    // Load collision on the frame boundary cycle.
    bus.digit_en = 4'b1111; bus.lz_blank = 1'b0;
    run_to(5);
    step_load(16'h9999);
    run_to(FR - 1);
    a0 = ack_cnt;
    step_load(16'h7777);
    chk("coll_ackA_now", ack_cnt - a0, 1);
    repeat (3) step();
    chk("coll_showA", bus.ssd_in, 9);
    wait_ack("coll_B");
    repeat (3) step();
    chk("coll_showB", bus.ssd_in, 7);
    repeat (2 * FR) step();
    chk("coll_total_acks", ack_cnt - a0, 2);

    // Reset before the boundary discards the pending load.
    run_to(3);
    step_load(16'h1234);
    run_to(8);
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    a0 = ack_cnt;
    nz = 0;
    step();
    chk("rst_mid_ctl0", bus.ssd_ctl, 4'b1111);
    step();
    chk("rst_mid_ctl1", bus.ssd_ctl, 4'b1110);
    for (int i = 0; i < 38; i++) begin
      step();
      if (bus.ssd_in != 4'h0) nz++;
    end
    chk("rst_mid_no_ack", ack_cnt - a0, 0);
    chk("rst_mid_disp_zero", nz, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
